bitrev_reorder_rt: RTL

Run-time-sized bit-reversal reorder buffer with output backpressure. It takes FFT output in bit-reversed order and emits it in natural order through a valid/ready interface. It sits between the FFT core and downstream consumers such as the magnitude or mel-filter stages. It extends the fixed-size ping-pong reorder with:
- a per-frame selectable size from 2 up to 2^MAX_BITS;
- input-ready and overflow reporting;
- output flow control.

---
 rtl/bitrev_reorder_rt.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bitrev_reorder_rt.sv
// bitrev_reorder_rt: run-time-sized bit-reversal reorder buffer.
// Two memory banks are used as a ping-pong pair. Frames arrive in bit-reversed
// order, are scattered into a bank at reversed addresses, and are then read out
// linearly in natural order through a valid/ready output register.
// Optional feature: define BRR_DO_LAST_EN to add the do_last output.
module bitrev_reorder_rt #(
    parameter int MAX_BITS = 10,
    parameter int WIDTH    = 16,
    parameter int CB       = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [CB-1:0]           cfg_bits,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    output logic                    di_ready,
    output logic                    do_valid,
    input  logic                    do_ready,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im,
`ifdef BRR_DO_LAST_EN
    output logic                    do_last,
`endif
    output logic                    ovf,
    input  logic                    clr_ovf,
    output logic                    busy
);

    localparam int DEPTH = 1 << MAX_BITS;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    bank_state_t         state     [2];
    bank_state_t         state_nxt [2];
    logic [CB-1:0]       fbits     [2];
    logic [CB-1:0]       fbits_nxt [2];
    logic                wb, wb_nxt;
    logic                rb, rb_nxt;
    logic [MAX_BITS-1:0] wr_cnt, wr_cnt_nxt;
    logic [MAX_BITS-1:0] rd_cnt, rd_cnt_nxt;

    logic [CB-1:0]       wr_fb;
    logic [MAX_BITS-1:0] wr_last;
    logic [MAX_BITS-1:0] wr_addr;
    logic [MAX_BITS-1:0] rd_last;
    logic                wr_fire, wr_done;
    logic                rd_fire, rd_done;

    // Bank index is the MSB of the memory address.
    logic [2*WIDTH-1:0]  mem [2*DEPTH];

    // Frame size request forced into the supported range 1..MAX_BITS.
    function automatic logic [CB-1:0] clamp_bits(input logic [CB-1:0] b);
        if (b == '0)
            return CB'(1);
        else if (b > CB'(MAX_BITS))
            return CB'(MAX_BITS);
        else
            return b;
    endfunction

    // Index of the final element of a frame of 2^fb samples.
    function automatic logic [MAX_BITS-1:0] last_index(input logic [CB-1:0] fb);
        return {MAX_BITS{1'b1}} >> (CB'(MAX_BITS) - fb);
    endfunction

    // Reverse the low fb bits of cnt; bits above fb come out as zero.
    function automatic logic [MAX_BITS-1:0] rev_addr(input logic [MAX_BITS-1:0] cnt,
                                                     input logic [CB-1:0]       fb);
        logic [MAX_BITS-1:0] r;
        for (int i = 0; i < MAX_BITS; i++)
            r[i] = cnt[MAX_BITS-1-i];
        return r >> (CB'(MAX_BITS) - fb);
    endfunction

    // Handshake decode: a new frame takes its size from cfg_bits, a running one keeps its own.
    always_comb begin
        wr_fb    = (state[wb] == EMPTY) ? clamp_bits(cfg_bits) : fbits[wb];
        wr_last  = last_index(wr_fb);
        wr_addr  = rev_addr(wr_cnt, wr_fb);
        di_ready = (state[wb] == EMPTY) || (state[wb] == FILLING);
        wr_fire  = di_en && di_ready;
        wr_done  = wr_fire && (wr_cnt == wr_last);
        rd_last  = last_index(fbits[rb]);
        rd_fire  = (state[rb] == DRAINING) && (!do_valid || do_ready);
        rd_done  = rd_fire && (rd_cnt == rd_last);
        busy     = (state[0] != EMPTY) || (state[1] != EMPTY) || do_valid;
    end

    // Bank state machine, pointers and counters: next-state logic.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            fbits_nxt[i] = fbits[i];
        end
        wb_nxt     = wb;
        rb_nxt     = rb;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;

        if (wr_fire) begin
            if (state[wb] == EMPTY) begin
                fbits_nxt[wb] = wr_fb;
                state_nxt[wb] = FILLING;
            end
            if (wr_done) begin
                state_nxt[wb] = FULL;
                wr_cnt_nxt    = '0;
                wb_nxt        = ~wb;
            end else begin
                wr_cnt_nxt = wr_cnt + 1'b1;
            end
        end

        if (state[rb] == FULL)
            state_nxt[rb] = DRAINING;

        if (rd_fire) begin
            if (rd_done) begin
                state_nxt[rb] = EMPTY;
                rb_nxt        = ~rb;
                rd_cnt_nxt    = '0;
                // Hand over straight to the other bank if it is (or is just becoming)
                // full, so consecutive frames leave the output without a bubble.
                if ((state[~rb] == FULL) || (wr_done && (wb == ~rb)))
                    state_nxt[~rb] = DRAINING;
            end else begin
                rd_cnt_nxt = rd_cnt + 1'b1;
            end
        end
    end

    // Bank state machine, pointers and counters: registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= EMPTY;
                fbits[i] <= '0;
            end
            wb     <= 1'b0;
            rb     <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                fbits[i] <= fbits_nxt[i];
            end
            wb     <= wb_nxt;
            rb     <= rb_nxt;
            wr_cnt <= wr_cnt_nxt;
            rd_cnt <= rd_cnt_nxt;
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (di_en && !di_ready)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

    // Sample memory write port, scattered to bit-reversed addresses.
    always_ff @(posedge clock) begin
        if (wr_fire)
            mem[{wb, wr_addr}] <= {di_re, di_im};
    end

    // Output register doubles as the synchronous memory read register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            do_valid <= 1'b0;
            do_re    <= '0;
            do_im    <= '0;
        end else if (rd_fire) begin
            do_valid       <= 1'b1;
            {do_re, do_im} <= mem[{rb, rd_cnt}];
        end else if (do_ready) begin
            do_valid <= 1'b0;
        end
    end

`ifdef BRR_DO_LAST_EN
    // End-of-frame marker travelling with the output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            do_last <= 1'b0;
        else if (rd_fire)
            do_last <= rd_done;
        else if (do_ready)
            do_last <= 1'b0;
    end
`endif

endmodule
